// File: rtl/branch_resolve_unit.sv
// Decode-side branch resolution: holds fetch-time prediction records, checks each
// against the actual outcome, and issues redirect/flush plus table update writes.
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             f_valid,
  input  logic [WIDTH-1:0] f_pc,
  input  logic             f_pred_taken,
  input  logic [WIDTH-1:0] f_pred_target,
  input  logic             stall,
  input  logic             d_valid,
  input  logic             d_is_branch,
  input  logic             d_taken,
  input  logic [WIDTH-1:0] d_target,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic             upd_valid,
  output logic [WIDTH-1:0] upd_pc,
  output logic [WIDTH-1:0] upd_target,
  output logic             upd_taken,
  input  logic             upd_ready,
  output logic             stall_req,
  output logic             q_err,
  output logic [CNTW-1:0]  br_count,
  output logic [CNTW-1:0]  mp_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] q_pc  [DEPTH];
  logic [WIDTH-1:0] q_tgt [DEPTH];
  logic             q_pt  [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    q_count_reg;

  logic [WIDTH-1:0] u_pc_reg    [2];
  logic [WIDTH-1:0] u_tgt_reg   [2];
  logic             u_taken_reg [2];
  logic             u_rd_reg, u_wr_reg;
  logic [1:0]       u_count_reg;

  logic             redirect_reg, q_err_reg;
  logic [WIDTH-1:0] redirect_pc_reg;
  logic [CNTW-1:0]  br_count_reg, mp_count_reg;

  logic [WIDTH-1:0] h_pc, h_tgt, correct_pc;
  logic             h_pt;
  logic             q_empty, q_full, pop_req, pop, push_req, push;
  logic             mispredict_now, upd_enq, upd_deq, upd_acc, u_full, err_now;

  assign h_pc  = q_pc[rd_ptr_reg];
  assign h_tgt = q_tgt[rd_ptr_reg];
  assign h_pt  = q_pt[rd_ptr_reg];

  always_comb begin
    q_empty        = (q_count_reg == '0);
    q_full         = (q_count_reg == CW'(DEPTH));
    pop_req        = d_valid & ~stall;
    pop            = pop_req & ~q_empty;
    mispredict_now = 1'b0;
    upd_enq        = 1'b0;
    correct_pc     = h_pc + WIDTH'(4);
    if (pop) begin
      if (d_is_branch) begin
        mispredict_now = (h_pt != d_taken) | (d_taken & (h_tgt != d_target));
        upd_enq        = 1'b1;
        if (d_taken) correct_pc = d_target;
      end else if (h_pt) begin
        // A non-branch predicted taken sent fetch down a bogus path.
        mispredict_now = 1'b1;
        upd_enq        = 1'b1;
      end
    end
    push_req = f_valid & ~stall & ~mispredict_now;
    push     = push_req & (~q_full | pop);
    u_full   = (u_count_reg == 2'd2);
    upd_deq  = (u_count_reg != 2'd0) & upd_ready;
    upd_acc  = upd_enq & (~u_full | upd_deq);
    err_now  = (push_req & q_full & ~pop) | (pop_req & q_empty) |
               (upd_enq & u_full & ~upd_deq);
  end

  // Record storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_reg]  <= f_pc;
      q_pt[wr_ptr_reg]  <= f_pred_taken;
      q_tgt[wr_ptr_reg] <= f_pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      q_count_reg     <= '0;
      u_rd_reg        <= 1'b0;
      u_wr_reg        <= 1'b0;
      u_count_reg     <= 2'd0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      q_err_reg       <= 1'b0;
      br_count_reg    <= '0;
      mp_count_reg    <= '0;
      for (int i = 0; i < 2; i++) begin
        u_pc_reg[i]    <= '0;
        u_tgt_reg[i]   <= '0;
        u_taken_reg[i] <= 1'b0;
      end
    end else begin
      if (mispredict_now) begin
        rd_ptr_reg  <= '0;
        wr_ptr_reg  <= '0;
        q_count_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        if (push && !pop)      q_count_reg <= q_count_reg + CW'(1);
        else if (!push && pop) q_count_reg <= q_count_reg - CW'(1);
      end

      if (upd_acc) begin
        u_pc_reg[u_wr_reg]    <= h_pc;
        u_tgt_reg[u_wr_reg]   <= d_target;
        u_taken_reg[u_wr_reg] <= d_taken & d_is_branch;
        u_wr_reg              <= ~u_wr_reg;
      end
      if (upd_deq) u_rd_reg <= ~u_rd_reg;
      if (upd_acc && !upd_deq)      u_count_reg <= u_count_reg + 2'd1;
      else if (!upd_acc && upd_deq) u_count_reg <= u_count_reg - 2'd1;

      redirect_reg <= mispredict_now;
      if (mispredict_now) redirect_pc_reg <= correct_pc;
      if (err_now) q_err_reg <= 1'b1;
      if (pop && d_is_branch && br_count_reg != '1) br_count_reg <= br_count_reg + CNTW'(1);
      if (mispredict_now && mp_count_reg != '1) mp_count_reg <= mp_count_reg + CNTW'(1);
    end
  end

  assign redirect    = redirect_reg;
  assign flush       = redirect_reg;
  assign redirect_pc = redirect_pc_reg;
  assign upd_valid   = (u_count_reg != 2'd0);
  assign upd_pc      = u_pc_reg[u_rd_reg];
  assign upd_target  = u_tgt_reg[u_rd_reg];
  assign upd_taken   = u_taken_reg[u_rd_reg];
  assign stall_req   = u_full;
  assign q_err       = q_err_reg;
  assign br_count    = br_count_reg;
  assign mp_count    = mp_count_reg;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based transaction model.
module tb_branch_resolve_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             f_valid, f_pred_taken, stall, d_valid, d_is_branch, d_taken, upd_ready;
  logic [WIDTH-1:0] f_pc, f_pred_target, d_target;
  logic             redirect, flush, upd_valid, upd_taken, stall_req, q_err;
  logic [WIDTH-1:0] redirect_pc, upd_pc, upd_target;
  logic [CNTW-1:0]  br_count, mp_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .stall(stall), .d_valid(d_valid), .d_is_branch(d_is_branch), .d_taken(d_taken),
    .d_target(d_target), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .stall_req(stall_req), .q_err(q_err),
    .br_count(br_count), .mp_count(mp_count)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic [WIDTH-1:0] pc; logic pt; logic [WIDTH-1:0] tgt; } rec_t;
  typedef struct { logic [WIDTH-1:0] pc; logic tk; logic [WIDTH-1:0] tgt; } upd_t;
  rec_t             pq[$];
  upd_t             uq[$];
  logic             m_redirect;
  logic [WIDTH-1:0] m_rpc;
  logic             m_err;
  int               m_br, m_mp;

  function automatic void model_reset();
    pq.delete(); uq.delete();
    m_redirect = 1'b0; m_rpc = '0; m_err = 1'b0; m_br = 0; m_mp = 0;
  endfunction

  function automatic void model_step();
    rec_t             h;
    upd_t             u;
    logic             mp = 1'b0;
    logic             enq = 1'b0;
    logic [WIDTH-1:0] cp = '0;
    h = '{default: '0};
    if (d_valid && !stall) begin
      if (pq.size() == 0) m_err = 1'b1;
      else begin
        h = pq.pop_front();
        if (d_is_branch) begin
          if (m_br < CMAX) m_br++;
          mp  = (h.pt != d_taken) || (d_taken && h.tgt != d_target);
          cp  = d_taken ? d_target : h.pc + 4;
          enq = 1'b1;
        end else if (h.pt) begin
          mp = 1'b1; cp = h.pc + 4; enq = 1'b1;
        end
        if (mp) pq.delete();
      end
    end
    if (f_valid && !stall && !mp) begin
      if (pq.size() < DEPTH) pq.push_back('{f_pc, f_pred_taken, f_pred_target});
      else m_err = 1'b1;
    end
    if (uq.size() > 0 && upd_ready) u = uq.pop_front();
    if (enq) begin
      if (uq.size() < 2) uq.push_back('{h.pc, d_taken && d_is_branch, d_target});
      else m_err = 1'b1;
    end
    m_redirect = mp;
    if (mp) begin
      m_rpc = cp;
      if (m_mp < CMAX) m_mp++;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("redirect", 64'(redirect), 64'(m_redirect));
    chk("flush", 64'(flush), 64'(m_redirect));
    if (m_redirect) chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    chk("upd_valid", 64'(upd_valid), 64'(uq.size() > 0));
    if (uq.size() > 0) begin
      chk("upd_pc", 64'(upd_pc), 64'(uq[0].pc));
      chk("upd_taken", 64'(upd_taken), 64'(uq[0].tk));
      chk("upd_target", 64'(upd_target), 64'(uq[0].tgt));
    end
    chk("stall_req", 64'(stall_req), 64'(uq.size() == 2));
    chk("q_err", 64'(q_err), 64'(m_err));
    chk("br_count", 64'(br_count), 64'(m_br));
    chk("mp_count", 64'(mp_count), 64'(m_mp));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".redirect"}, 64'(redirect), 64'd0);
    chk({tag, ".flush"}, 64'(flush), 64'd0);
    chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'd0);
    chk({tag, ".upd_valid"}, 64'(upd_valid), 64'd0);
    chk({tag, ".upd_pc"}, 64'(upd_pc), 64'd0);
    chk({tag, ".upd_taken"}, 64'(upd_taken), 64'd0);
    chk({tag, ".upd_target"}, 64'(upd_target), 64'd0);
    chk({tag, ".stall_req"}, 64'(stall_req), 64'd0);
    chk({tag, ".q_err"}, 64'(q_err), 64'd0);
    chk({tag, ".br_count"}, 64'(br_count), 64'd0);
    chk({tag, ".mp_count"}, 64'(mp_count), 64'd0);
  endtask

  task automatic drive(input logic fv, input logic [WIDTH-1:0] fpc, input logic fpt,
                       input logic [WIDTH-1:0] ftgt, input logic st, input logic dv,
                       input logic db, input logic dt, input logic [WIDTH-1:0] dtgt,
                       input logic ur);
    f_valid = fv; f_pc = fpc; f_pred_taken = fpt; f_pred_target = ftgt;
    stall = st; d_valid = dv; d_is_branch = db; d_taken = dt; d_target = dtgt;
    upd_ready = ur;
  endtask

  // Advance one clock: model and DUT see the same inputs; sample 1 time unit after the edge.
  task automatic step(input logic use_model);
    model_step();
    @(posedge clk);
    #1;
    if (use_model) check_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, '0, 0, '0, 0, 0, 0, 0, '0, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic fv; logic [WIDTH-1:0] fpc; logic fpt; logic [WIDTH-1:0] ftgt;
    logic st; logic dv; logic db; logic dt; logic [WIDTH-1:0] dtgt; logic ur;
    logic e_rd; logic [WIDTH-1:0] e_rpc; logic e_uv; logic [WIDTH-1:0] e_upc; logic e_ut;
    logic [WIDTH-1:0] e_utgt; logic e_sr; logic e_err; int e_br; int e_mp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // fv fpc pt ftgt | st dv br tk dtgt | ur || rd rpc | uv upc ut utgt | sr err br mp
    tbl[0]  = '{1, 32'h1,  0, 32'h0,  0, 0, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 0, 0};
    tbl[1]  = '{1, 32'h2,  0, 32'h0,  0, 1, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 0, 0};
    tbl[2]  = '{1, 32'h3,  0, 32'h0,  0, 1, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 0, 0};
    tbl[3]  = '{0, 32'h0,  0, 32'h0,  0, 1, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 0, 0};
    tbl[4]  = '{1, 32'h3,  0, 32'h0,  0, 0, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 0, 0};
    tbl[5]  = '{1, 32'h99, 0, 32'h0,  0, 1, 1, 1, 32'h50, 1, 1, 32'h50, 1, 32'h3,  1, 32'h50, 0, 0, 1, 1};
    tbl[6]  = '{1, 32'h51, 1, 32'h10, 0, 0, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 1, 1};
    tbl[7]  = '{0, 32'h0,  0, 32'h0,  0, 1, 1, 0, 32'h77, 1, 1, 32'h55, 1, 32'h51, 0, 32'h77, 0, 0, 2, 2};
    tbl[8]  = '{1, 32'h23, 1, 32'h88, 0, 0, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 2, 2};
    tbl[9]  = '{1, 32'h77, 1, 32'h10, 1, 1, 1, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 2, 2};
    tbl[10] = '{0, 32'h0,  0, 32'h0,  0, 1, 1, 1, 32'h88, 1, 0, 32'h0,  1, 32'h23, 1, 32'h88, 0, 0, 3, 2};
    tbl[11] = '{0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 0, 3, 2};
  end

  initial begin
    reset_n = 1'b0;
    drive(0, '0, 0, '0, 0, 0, 0, 0, '0, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    $display("reset: outputs checked");
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].fv, tbl[i].fpc, tbl[i].fpt, tbl[i].ftgt, tbl[i].st, tbl[i].dv,
            tbl[i].db, tbl[i].dt, tbl[i].dtgt, tbl[i].ur);
      step(1'b0);
      chk($sformatf("vec%0d.redirect", i), 64'(redirect), 64'(tbl[i].e_rd));
      chk($sformatf("vec%0d.flush", i), 64'(flush), 64'(tbl[i].e_rd));
      if (tbl[i].e_rd) chk($sformatf("vec%0d.redirect_pc", i), 64'(redirect_pc), 64'(tbl[i].e_rpc));
      chk($sformatf("vec%0d.upd_valid", i), 64'(upd_valid), 64'(tbl[i].e_uv));
      if (tbl[i].e_uv) begin
        chk($sformatf("vec%0d.upd_pc", i), 64'(upd_pc), 64'(tbl[i].e_upc));
        chk($sformatf("vec%0d.upd_taken", i), 64'(upd_taken), 64'(tbl[i].e_ut));
        chk($sformatf("vec%0d.upd_target", i), 64'(upd_target), 64'(tbl[i].e_utgt));
      end
      chk($sformatf("vec%0d.stall_req", i), 64'(stall_req), 64'(tbl[i].e_sr));
      chk($sformatf("vec%0d.q_err", i), 64'(q_err), 64'(tbl[i].e_err));
      chk($sformatf("vec%0d.br_count", i), 64'(br_count), 64'(tbl[i].e_br));
      chk($sformatf("vec%0d.mp_count", i), 64'(mp_count), 64'(tbl[i].e_mp));
      $display("vec %0d: redirect=%0b rpc=%0h upd_valid=%0b upd_pc=%0h br=%0d mp=%0d",
               i, redirect, redirect_pc, upd_valid, upd_pc, br_count, mp_count);
    end

    // Update backpressure: two correct not-taken resolves fill the buffer, a third is dropped.
    drive(1, 32'h100, 0, '0, 0, 0, 0, 0, '0, 0);            step(1'b1);
    drive(1, 32'h104, 0, '0, 0, 1, 1, 0, 32'h200, 0);       step(1'b1);
    drive(1, 32'h108, 0, '0, 0, 1, 1, 0, 32'h204, 0);       step(1'b1);
    chk("bp.stall_req_full", 64'(stall_req), 64'd1);
    chk("bp.head_pc", 64'(upd_pc), 64'h100);
    chk("bp.err_before_drop", 64'(q_err), 64'd0);
    $display("bp: buffer full stall_req=%0b upd_pc=%0h", stall_req, upd_pc);
    drive(0, '0, 0, '0, 0, 1, 1, 0, 32'h208, 0);            step(1'b1);
    chk("bp.drop_err", 64'(q_err), 64'd1);
    chk("bp.head_stable", 64'(upd_pc), 64'h100);
    chk("bp.head_tgt_stable", 64'(upd_target), 64'h200);
    $display("bp: third resolve dropped q_err=%0b", q_err);
    drive(0, '0, 0, '0, 0, 0, 0, 0, '0, 1);                 step(1'b1);
    chk("bp.drain1_pc", 64'(upd_pc), 64'h104);
    chk("bp.drain1_stall_req", 64'(stall_req), 64'd0);
    step(1'b1);
    chk("bp.drained", 64'(upd_valid), 64'd0);
    $display("bp: drained upd_valid=%0b stall_req=%0b", upd_valid, stall_req);

    // Asynchronous reset mid-stream, between clock edges.
    drive(1, 32'h300, 1, 32'h40, 0, 0, 0, 0, '0, 0);        step(1'b1);
    drive(1, 32'h304, 0, '0, 0, 1, 1, 0, 32'h10, 0);        step(1'b1);
    reset_n = 1'b0;
    #2;
    chk_zero("async_reset");
    $display("async reset: outputs checked without a clock edge");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Queue boundaries: fill, legal push+pop while full (pointer wrap), then overflow.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h10 + 32'(i * 4), 0, '0, 0, 0, 0, 0, '0, 1);
      step(1'b1);
    end
    drive(1, 32'h20, 0, '0, 0, 1, 0, 0, '0, 1);             step(1'b1);
    chk("bnd.full_pushpop_err", 64'(q_err), 64'd0);
    drive(1, 32'h24, 0, '0, 0, 0, 0, 0, '0, 1);             step(1'b1);
    chk("bnd.overflow_err", 64'(q_err), 64'd1);
    $display("bnd: overflow q_err=%0b", q_err);
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 0, '0, 0, 1, 1, 0, 32'h400, 1);
      step(1'b1);
      chk($sformatf("bnd.order%0d", i), 64'(upd_pc), 64'h14 + 64'(i * 4));
      $display("bnd: pop %0d upd_pc=%0h", i, upd_pc);
    end

    // Underflow on an empty queue after a fresh reset.
    do_reset();
    drive(0, '0, 0, '0, 0, 1, 1, 1, 32'h80, 1);             step(1'b1);
    chk("underflow_err", 64'(q_err), 64'd1);
    chk("underflow_no_br", 64'(br_count), 64'd0);
    $display("underflow: q_err=%0b", q_err);

    // pc+4 wraps modulo 2^WIDTH.
    do_reset();
    drive(1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0, 0, '0, 1);  step(1'b1);
    drive(0, '0, 0, '0, 0, 1, 1, 0, 32'h40, 1);             step(1'b1);
    chk("wrap_rpc", 64'(redirect_pc), 64'h0);
    $display("wrap: redirect_pc=%0h", redirect_pc);

    // Randomized traffic against the model, several segments each from reset.
    for (int seg = 0; seg < 6; seg++) begin
      int bad_before;
      bad_before = bad;
      do_reset();
      for (int c = 0; c < 300; c++) begin
        logic [WIDTH-1:0] fpc, ftgt, dtgt;
        fpc  = (seg == 5 && $urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 63) * 4);
        ftgt = $urandom_range(0, 1) ? 32'h40 : 32'h80;
        dtgt = $urandom_range(0, 1) ? 32'h40 : 32'h80;
        drive($urandom_range(0, 99) < 65, fpc, 1'($urandom_range(0, 1)), ftgt,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), dtgt,
              $urandom_range(0, 99) < 60);
        step(1'b1);
      end
      $display("random segment %0d: br=%0d mp=%0d q_err=%0b new_bad=%0d",
               seg, br_count, mp_count, q_err, bad - bad_before);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
